vect_hazard_unit: RTL
=====================

VECT_HAZARD_UNIT -- requirements
Module: vect_hazard_unit

Interface
REQ-001 SHALL have parameter RA, default 4: vector register address width (16 registers).
REQ-002 SHALL have parameter CW, default 16: stall performance counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports id_rs1, id_rs2, id_rs3, input, RA each: decode-stage source registers.
REQ-006 SHALL have ports id_use1, id_use2, id_use3, input, 1 each: source actually read; id_use2=0 means the instruction takes the immediate.
REQ-007 SHALL have ports id_rd (input, RA), id_regwrite (input, 1), id_memread (input, 1), id_valid (input, 1): decode-stage destination, write enable, load flag, valid.
REQ-008 SHALL have port flush, input, 1: branch kill of the ID and EX slots.
REQ-009 SHALL have ports Fa, Fb, Fc, output, 1 each: registered forward selects for execute operands 1, 2, 3 (1 = take the MEM-stage result).
REQ-010 SHALL have port stall, output, 1: combinational; holds PC and the ID register and injects a bubble into EX.
REQ-011 SHALL have port stall_count, output, CW: saturating count of stall cycles.

Function
REQ-012 SHALL keep internal EX-slot and MEM-slot records {valid, rd, regwrite, memread}.
REQ-013 On each edge with stall=0 and flush=0, SHALL move EX to MEM and load ID into EX (EX.valid=id_valid).
REQ-014 On each edge with stall=1, SHALL move EX to MEM and load a bubble into EX (valid=0).
REQ-015 On each edge with flush=1, SHALL clear EX.valid and still move the old EX to MEM; flush has priority over stall.
REQ-016 A source i SHALL match a slot when id_valid, id_usei, slot.valid, slot.regwrite are all 1 and id_rsi==slot.rd.
REQ-017 stall SHALL be 1 when any source matches the EX slot with memread=1, or matches the MEM slot; otherwise 0.
REQ-018 stall SHALL be forced to 0 when flush=1.
REQ-019 A load-use at distance 1 SHALL therefore stall exactly 2 cycles; any producer at distance 2 SHALL stall exactly 1 cycle. The register file provides write-before-read in WB.
REQ-020 Fa/Fb/Fc SHALL be updated only on edges where ID advances into EX. Fx is set to 1 when source x matches the EX slot with memread=0; otherwise Fx is set to 0.
REQ-021 On stall or flush edges, Fa/Fb/Fc SHALL be set to 0, because the bubble takes no forward.
REQ-022 Fb SHALL be 0 whenever id_use2=0, so that the operand-2 select {Fb,immSrc} never reaches 11.
REQ-023 Register 0 SHALL receive no special treatment; all RA-bit addresses are equal.
REQ-024 stall_count SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 2^CW-1.

Reset
REQ-025 With rst=1 at an edge, SHALL clear both slot valids, Fa, Fb, Fc and stall_count; rst has priority over flush and stall.
REQ-026 During reset and in the first cycle after it, stall SHALL be 0, because all slots are invalid.
REQ-027 Reset asserted mid-stall SHALL abandon the stall; the next ID instruction enters EX with no forward.

Verification
REQ-028 ALU r3<-... then the next instruction uses rs1=3 -> no stall; that instruction enters EX with Fa=1, Fb=0, Fc=0.
REQ-029 Load r5 then the next instruction uses rs2=5, id_use2=1 -> stall=1 for 2 cycles, stall_count +2; instruction enters EX with Fb=0.
REQ-030 ALU r7, one independent instruction, then use rs3=7 -> 1 stall cycle, Fc=0 on entry.
REQ-031 Instruction with id_use2=0 and id_rs2 equal to the prior ALU rd -> no stall, Fb=0.
REQ-032 Load r2 followed by a dependent instruction with flush=1 on the dependent's first ID cycle -> stall=0 and EX slot cleared; rst during a 2-cycle stall -> all outputs 0 on the next cycle.
REQ-033 Force 2^CW+3 stall cycles with CW=4 -> stall_count holds 15.

Source files
------------

// File: rtl/vect_hazard_unit.sv
// Load-use / distance-2 hazard detection with registered forward selects for a
// three-source vector pipeline; tracks the EX and MEM slots and counts stall cycles.
module vect_hazard_unit #(
  parameter int RA = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RA-1:0] id_rs1,
  input  logic [RA-1:0] id_rs2,
  input  logic [RA-1:0] id_rs3,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic          id_use3,
  input  logic [RA-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_valid,
  input  logic          flush,
  output logic          Fa,
  output logic          Fb,
  output logic          Fc,
  output logic          stall,
  output logic [CW-1:0] stall_count
);

  typedef struct packed {
    logic          valid;
    logic [RA-1:0] rd;
    logic          regwrite;
    logic          memread;
  } slot_t;

  slot_t              id_slot;
  slot_t              ex_slot;
  slot_t              mem_slot;
  logic [2:0][RA-1:0] rs_v;
  logic [2:0]         use_v;
  logic [2:0]         hit_ex;
  logic [2:0]         hit_mem;
  logic               advance;

  assign id_slot = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
  assign rs_v    = {id_rs3, id_rs2, id_rs1};
  assign use_v   = {id_use3, id_use2, id_use1};

  always_comb begin
    hit_ex  = '0;
    hit_mem = '0;
    for (int i = 0; i < 3; i++) begin
      hit_ex[i]  = id_valid && use_v[i] && ex_slot.valid && ex_slot.regwrite
                   && (rs_v[i] == ex_slot.rd);
      hit_mem[i] = id_valid && use_v[i] && mem_slot.valid && mem_slot.regwrite
                   && (rs_v[i] == mem_slot.rd);
    end
  end

  // A load in EX has no result yet, and the MEM-stage value is not forwarded,
  // so both cases wait until the producer reaches the write-before-read WB stage.
  assign stall   = ~rst & ~flush & ((|(hit_ex & {3{ex_slot.memread}})) | (|hit_mem));
  assign advance = ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot.valid  <= 1'b0;
      mem_slot.valid <= 1'b0;
      {Fc, Fb, Fa}   <= 3'b000;
      stall_count    <= '0;
    end else begin
      mem_slot <= ex_slot;
      if (advance) begin
        ex_slot      <= id_slot;
        {Fc, Fb, Fa} <= hit_ex & ~{3{ex_slot.memread}};
      end else begin
        ex_slot.valid <= 1'b0;
        {Fc, Fb, Fa}  <= 3'b000;
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
